aes_key_expander_multimode: RTL and testbench

Run-time multi-mode AES key expander. It produces the full round-key schedule for AES-128, AES-192 or AES-256 from one 256-bit key port, computing a parametrised number of key words per clock. The round keys sit in an internal register file with a registered random-access read port, so the cipher datapath no longer needs a 1920-bit flat vector. It sits between the key-load interface and the AES/GCM round pipeline, in place of the fixed-mode sequential scheduler.

---
 rtl/aes_key_pkg.sv | 103 ++++++++++
 rtl/aes_key_expander_multimode_if.sv | 37 +++
 rtl/aes_key_word_step.sv | 55 +++++
 rtl/aes_key_expander_multimode.sv | 167 ++++++++++++++++
 tb/tb_aes_key_expander_multimode.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_pkg.sv
// ============================================================================
// Module      : aes_key_pkg
// Description : Shared types, mode lookups, Rcon table and S-box for the
//               multi-mode AES key expander.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_key_pkg;

    localparam int NB_WORD = 32;

    typedef enum logic [1:0] {
        KEY_MODE_128  = 2'd0,
        KEY_MODE_192  = 2'd1,
        KEY_MODE_256  = 2'd2,
        KEY_MODE_RSVD = 2'd3
    } key_mode_e;

    localparam logic [7:0] RCON_TABLE [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Key length in words (Nk)
    function automatic logic [3:0] nk_of(input logic [1:0] mode);
        case (mode)
            KEY_MODE_128: return 4'd4;
            KEY_MODE_192: return 4'd6;
            default:      return 4'd8;
        endcase
    endfunction

    // Number of rounds (Nr)
    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            KEY_MODE_128: return 4'd10;
            KEY_MODE_192: return 4'd12;
            default:      return 4'd14;
        endcase
    endfunction

    // Total schedule length in words, 4*(Nr+1)
    function automatic logic [6:0] total_words(input logic [1:0] mode);
        case (mode)
            KEY_MODE_128: return 7'd44;
            KEY_MODE_192: return 7'd52;
            default:      return 7'd60;
        endcase
    endfunction

    // Rcon for round index 1..10, zero elsewhere
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        if ((idx >= 4'd1) && (idx <= 4'd10)) begin
            return RCON_TABLE[idx - 4'd1];
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        p = x;
        for (int k = 0; k < 6; k++) begin
            p = gf_mul(gf_mul(p, p), x);
        end
        return gf_mul(p, p);
    endfunction

    // S-box: field inverse followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [NB_WORD-1:0] sub_word(input logic [NB_WORD-1:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [NB_WORD-1:0] rot_word(input logic [NB_WORD-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_key_expander_multimode_if.sv
// ============================================================================
// Module      : aes_key_expander_multimode_if
// Description : Control, key-load and read-port bundle of the key expander.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_key_expander_multimode_if
    import aes_key_pkg::*;
#(
    parameter int NB_BYTE       = 8,
    parameter int N_BYTES_STATE = 16
);
    logic                              i_valid;
    logic                              i_trigger_schedule;
    logic [1:0]                        i_key_mode;
    logic [8*NB_WORD-1:0]              i_key;
    logic                              i_rd_en;
    logic [3:0]                        i_rd_round;
    logic [NB_BYTE*N_BYTES_STATE-1:0]  o_rd_key;
    logic                              o_rd_valid;
    logic                              o_busy;
    logic                              o_done;
    logic                              o_mode_err;

    modport master (
        output i_valid, i_trigger_schedule, i_key_mode, i_key, i_rd_en, i_rd_round,
        input  o_rd_key, o_rd_valid, o_busy, o_done, o_mode_err
    );

    modport slave (
        input  i_valid, i_trigger_schedule, i_key_mode, i_key, i_rd_en, i_rd_round,
        output o_rd_key, o_rd_valid, o_busy, o_done, o_mode_err
    );
endinterface

`default_nettype wire

// File: rtl/aes_key_word_step.sv
// ============================================================================
// Module      : aes_key_word_step
// Description : One key-schedule word: w[i] = w[i-Nk] ^ f(w[i-1]).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_key_word_step
    import aes_key_pkg::*;
(
    input  wire logic [NB_WORD-1:0] i_w_prev,
    input  wire logic [NB_WORD-1:0] i_w_nk,
    input  wire logic [6:0]         i_word_idx,
    input  wire logic [3:0]         i_nk,
    output logic      [NB_WORD-1:0] o_word
);
    logic [6:0]         w_rem;
    logic [6:0]         w_quot;
    logic [NB_WORD-1:0] w_f;

    // Position of the word inside its Nk-word group and the group number
    always_comb begin
        w_rem  = '0;
        w_quot = '0;
        case (i_nk)
            4'd4: begin
                w_rem  = {5'd0, i_word_idx[1:0]};
                w_quot = i_word_idx >> 2;
            end
            4'd6: begin
                w_rem  = i_word_idx % 7'd6;
                w_quot = i_word_idx / 7'd6;
            end
            default: begin
                w_rem  = {4'd0, i_word_idx[2:0]};
                w_quot = i_word_idx >> 3;
            end
        endcase
    end

    // Select the non-linear function for this word position
    always_comb begin
        w_f = i_w_prev;
        if (w_rem == 7'd0) begin
            w_f = sub_word(rot_word(i_w_prev)) ^ {rcon(w_quot[3:0]), 24'h000000};
        end else if ((i_nk == 4'd8) && (w_rem == 7'd4)) begin
            w_f = sub_word(i_w_prev);
        end
    end

    assign o_word = i_w_nk ^ w_f;

endmodule

`default_nettype wire

// File: rtl/aes_key_expander_multimode.sv
// ============================================================================
// Module      : aes_key_expander_multimode
// Description : Run-time AES-128/192/256 key expander with a word register
//               file and a registered round-key read port.
//               Optional: AES_KEYEXP_FLAT_VECTOR_EN adds o_round_key_vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_key_expander_multimode
    import aes_key_pkg::*;
#(
    parameter int NB_BYTE         = 8,
    parameter int N_BYTES_STATE   = 16,
    parameter int N_WORDS_PER_CYC = 2,
    parameter int N_ROUNDS_MAX    = 14
)(
    input  wire logic                    i_clock,
    input  wire logic                    i_reset,
    aes_key_expander_multimode_if.slave  bus
`ifdef AES_KEYEXP_FLAT_VECTOR_EN
    ,
    output logic [128*(N_ROUNDS_MAX+1)-1:0] o_round_key_vector
`endif
);
    localparam int c_RK_BITS = NB_BYTE * N_BYTES_STATE;
    localparam int c_WPR     = c_RK_BITS / NB_WORD;
    localparam int c_N_WORDS = c_WPR * (N_ROUNDS_MAX + 1);
    localparam int c_AW      = $clog2(c_N_WORDS);
    localparam int c_IDX_W   = 7;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    if ((NB_BYTE != 8) || !((N_WORDS_PER_CYC == 1) || (N_WORDS_PER_CYC == 2) ||
                            (N_WORDS_PER_CYC == 4))) begin : g_bad_cfg
        $error("aes_key_expander_multimode: unsupported NB_BYTE / N_WORDS_PER_CYC");
    end

    logic [0:0]           r_state;
    logic [c_IDX_W-1:0]   r_wc;
    logic [1:0]           r_mode;
    logic [NB_WORD-1:0]   r_words [0:c_N_WORDS-1];
    logic [c_RK_BITS-1:0] r_rd_key;
    logic                 r_rd_valid;
    logic                 r_done;
    logic                 r_mode_err;

    logic                 w_trigger;
    logic                 w_trig_ok;
    logic                 w_step_en;
    logic                 w_last;
    logic [3:0]           w_nk;
    logic [c_IDX_W-1:0]   w_total;
    logic [c_IDX_W-1:0]   w_prev_idx;
    logic [NB_WORD-1:0]   w_chain [0:N_WORDS_PER_CYC];
    logic [c_RK_BITS-1:0] w_rd_key;

    assign w_trigger  = bus.i_valid & bus.i_trigger_schedule;
    assign w_trig_ok  = w_trigger & (bus.i_key_mode != KEY_MODE_RSVD);
    assign w_step_en  = bus.i_valid & (r_state == c_ST_BUSY);
    assign w_nk       = nk_of(r_mode);
    assign w_total    = total_words(r_mode);
    assign w_last     = (r_wc + c_IDX_W'(N_WORDS_PER_CYC)) >= w_total;
    assign w_prev_idx = r_wc - 7'd1;
    assign w_chain[0] = (w_prev_idx < c_IDX_W'(c_N_WORDS)) ? r_words[c_AW'(w_prev_idx)] : '0;

    // Chain of word computations; word j feeds word j+1 within the cycle
    for (genvar j = 0; j < N_WORDS_PER_CYC; j++) begin : g_step
        logic [c_IDX_W-1:0] w_idx;
        logic [c_IDX_W-1:0] w_nk_idx;
        logic [NB_WORD-1:0] w_nk_word;

        assign w_idx     = r_wc + c_IDX_W'(j);
        assign w_nk_idx  = w_idx - {3'b000, w_nk};
        assign w_nk_word = (w_nk_idx < c_IDX_W'(c_N_WORDS)) ? r_words[c_AW'(w_nk_idx)] : '0;

        aes_key_word_step u_step (
            .i_w_prev   (w_chain[j]),
            .i_w_nk     (w_nk_word),
            .i_word_idx (w_idx),
            .i_nk       (w_nk),
            .o_word     (w_chain[j+1])
        );
    end

    // Read-port word gather; round w[4r] lands in the MSBs
    for (genvar q = 0; q < c_WPR; q++) begin : g_rd
        assign w_rd_key[c_RK_BITS-1-NB_WORD*q -: NB_WORD] =
            (bus.i_rd_round <= 4'(N_ROUNDS_MAX)) ? r_words[{bus.i_rd_round, 2'(q)}] : '0;
    end

    // Control: trigger restarts, enabled busy cycles advance the counter
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= c_ST_IDLE;
            r_wc       <= '0;
            r_mode     <= KEY_MODE_128;
            r_done     <= 1'b0;
            r_mode_err <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_mode_err <= w_trigger & (bus.i_key_mode == KEY_MODE_RSVD);
            if (w_trig_ok) begin
                r_mode  <= bus.i_key_mode;
                r_wc    <= {3'b000, nk_of(bus.i_key_mode)};
                r_state <= c_ST_BUSY;
            end else if (w_step_en) begin
                r_wc <= r_wc + c_IDX_W'(N_WORDS_PER_CYC);
                if (w_last) begin
                    r_state <= c_ST_IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    // Register file: key load on trigger, computed words while busy
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < c_N_WORDS; k++) begin
                r_words[c_AW'(k)] <= '0;
            end
        end else if (w_trig_ok) begin
            for (int k = 0; k < 8; k++) begin
                if (k < int'(nk_of(bus.i_key_mode))) begin
                    r_words[c_AW'(k)] <= bus.i_key[8*NB_WORD-1-NB_WORD*k -: NB_WORD];
                end
            end
        end else if (w_step_en) begin
            for (int k = 0; k < N_WORDS_PER_CYC; k++) begin
                if ((r_wc + c_IDX_W'(k)) < w_total) begin
                    r_words[c_AW'(r_wc + c_IDX_W'(k))] <= w_chain[k+1];
                end
            end
        end
    end

    // Registered read port; rounds beyond the latched Nr read as zero
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rd_key   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.i_rd_en;
            if (bus.i_rd_en) begin
                r_rd_key <= (bus.i_rd_round > nr_of(r_mode)) ? '0 : w_rd_key;
            end
        end
    end

`ifdef AES_KEYEXP_FLAT_VECTOR_EN
    for (genvar r = 0; r <= N_ROUNDS_MAX; r++) begin : g_flat
        assign o_round_key_vector[128*r +: 128] =
            {r_words[4*r], r_words[4*r+1], r_words[4*r+2], r_words[4*r+3]};
    end
`endif

    assign bus.o_rd_key   = r_rd_key;
    assign bus.o_rd_valid = r_rd_valid;
    assign bus.o_busy     = (r_state == c_ST_BUSY);
    assign bus.o_done     = r_done;
    assign bus.o_mode_err = r_mode_err;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expander_multimode.sv
// ============================================================================
// Module      : tb_aes_key_expander_multimode
// Description : Self-checking bench for the multi-mode AES key expander.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_key_expander_multimode;

    localparam int W = 2;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_key_expander_multimode_if bus ();
`ifdef AES_KEYEXP_FLAT_VECTOR_EN
    logic [128*15-1:0] flat_vec;
`endif

    aes_key_expander_multimode #(
        .NB_BYTE         (8),
        .N_BYTES_STATE   (16),
        .N_WORDS_PER_CYC (W),
        .N_ROUNDS_MAX    (14)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
`ifdef AES_KEYEXP_FLAT_VECTOR_EN
        ,
        .o_round_key_vector (flat_vec)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  sbox_t [0:255];
    logic [31:0] mw [0:59];
    int          m_nk;
    int          m_nr;

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from the generator-3 log walk (independent of the inversion form)
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
    endfunction

    task automatic model_expand(input logic [255:0] key, input int mode);
        logic [31:0] t;
        logic [7:0]  rc;
        int total;
        m_nk  = (mode == 0) ? 4 : (mode == 1) ? 6 : 8;
        m_nr  = m_nk + 6;
        total = 4 * (m_nr + 1);
        for (int i = 0; i < m_nk; i++) mw[i] = key[255 - 32*i -: 32];
        for (int i = m_nk; i < total; i++) begin
            t = mw[i-1];
            if (i % m_nk == 0) begin
                t  = subw({t[23:0], t[31:24]});
                rc = 8'h01;
                for (int n = 1; n < i / m_nk; n++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                t[31:24] = t[31:24] ^ rc;
            end else if (m_nk == 8 && i % 8 == 4) begin
                t = subw(t);
            end
            mw[i] = mw[i - m_nk] ^ t;
        end
    endtask

    function automatic logic [127:0] model_round(input int r);
        if (r > m_nr) return '0;
        return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endfunction

    function automatic int cycles_of(input int mode);
        int nk, t;
        nk = (mode == 0) ? 4 : (mode == 1) ? 6 : 8;
        t  = 4 * (nk + 7);
        return (t - nk + W - 1) / W;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [255:0] key, input logic [1:0] mode);
        bus.i_key              = key;
        bus.i_key_mode         = mode;
        bus.i_valid            = 1'b1;
        bus.i_trigger_schedule = 1'b1;
        step();
        bus.i_trigger_schedule = 1'b0;
        bus.i_valid            = 1'b0;
    endtask

    task automatic run_to_done(input bit rand_valid, output int enabled, output int stalls);
        bit v;
        bit seen;
        enabled = 0;
        stalls  = 0;
        seen    = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.i_valid = v;
            step();
            if (v) enabled++; else stalls++;
            if (bus.o_done) seen = 1'b1;
        end
        bus.i_valid = 1'b0;
        if (!seen) check("done_timeout", 128'(0), 128'(1));
    endtask

    task automatic read_round(input int r, output logic [127:0] key);
        bus.i_rd_en    = 1'b1;
        bus.i_rd_round = 4'(r);
        step();
        key = bus.o_rd_key;
        check("rd_valid", 128'(bus.o_rd_valid), 128'(1));
        bus.i_rd_en = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [127:0] k;
        for (int r = 0; r < 16; r++) begin
            read_round(r, k);
            check($sformatf("%s_round%0d", tag, r), k, model_round(r));
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] k;
        logic [255:0] rkey;
        int en, st, mode, dones;

        build_sbox();
        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_trigger_schedule = 1'b0; bus.i_key_mode = 2'd0;
        bus.i_key = '0; bus.i_rd_en = 1'b0; bus.i_rd_round = 4'd0;
        step(); step();
        check("rst_rd_key",   bus.o_rd_key, 128'(0));
        check("rst_rd_valid", 128'(bus.o_rd_valid), 128'(0));
        check("rst_busy",     128'(bus.o_busy), 128'(0));
        check("rst_done",     128'(bus.o_done), 128'(0));
        check("rst_mode_err", 128'(bus.o_mode_err), 128'(0));
        rst = 1'b0;
        step();
        read_round(0, k);
        check("rst_regfile", k, 128'(0));

        // AES-128 vector
        model_expand(K128, 0);
        start(K128, 2'd0);
        check("busy_after_trig", 128'(bus.o_busy), 128'(1));
        run_to_done(1'b0, en, st);
        check("aes128_cycles", 128'(en), 128'(cycles_of(0)));
        check("aes128_busy_clr", 128'(bus.o_busy), 128'(0));
        bus.i_valid = 1'b1; step(); bus.i_valid = 1'b0;
        check("done_one_cycle", 128'(bus.o_done), 128'(0));
        read_round(10, k);
        check("aes128_r10_vec", k, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_all("aes128");

        // AES-192 vector
        model_expand(K192, 1);
        start(K192, 2'd1);
        run_to_done(1'b0, en, st);
        check("aes192_cycles", 128'(en), 128'(cycles_of(1)));
        read_round(12, k);
        check("aes192_r12_vec", k, 128'he98ba06f448c773c8ecc720401002202);
        read_round(13, k);
        check("aes192_r13_zero", k, 128'(0));

        // AES-256 vector, then again with i_valid toggling
        model_expand(K256, 2);
        start(K256, 2'd2);
        run_to_done(1'b0, en, st);
        check("aes256_cycles", 128'(en), 128'(cycles_of(2)));
        read_round(14, k);
        check("aes256_r14_vec", k, 128'hfe4890d1e6188d0b046df344706c631e);
        start(K256, 2'd2);
        run_to_done(1'b1, en, st);
        check("aes256_stall_cycles", 128'(en), 128'(cycles_of(2)));
        check_all("aes256_stall");

        // Random keys and modes with random stalls
        for (int it = 0; it < 6; it++) begin
            for (int w = 0; w < 8; w++) rkey[32*w +: 32] = $urandom();
            mode = $urandom_range(0, 2);
            model_expand(rkey, mode);
            start(rkey, 2'(mode));
            run_to_done(1'b1, en, st);
            check($sformatf("rand%0d_cycles", it), 128'(en), 128'(cycles_of(mode)));
            check_all($sformatf("rand%0d", it));
        end

        // Retrigger with AES-128 during an AES-256 expansion
        start(K256, 2'd2);
        dones = 0;
        bus.i_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            if (bus.o_done) dones++;
        end
        model_expand(K128, 0);
        start(K128, 2'd0);
        run_to_done(1'b0, en, st);
        check("retrig_cycles", 128'(en), 128'(cycles_of(0)));
        bus.i_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            if (bus.o_done) dones++;
        end
        bus.i_valid = 1'b0;
        check("retrig_extra_done", 128'(dones), 128'(0));
        check_all("retrig");

        // Trigger coinciding with the final busy cycle
        for (int w = 0; w < 8; w++) rkey[32*w +: 32] = $urandom();
        start(rkey, 2'd1);
        bus.i_valid = 1'b1;
        for (int n = 0; n < cycles_of(1) - 1; n++) step();
        bus.i_key = K128; bus.i_key_mode = 2'd0; bus.i_trigger_schedule = 1'b1;
        step();
        bus.i_trigger_schedule = 1'b0; bus.i_valid = 1'b0;
        check("final_trig_no_done", 128'(bus.o_done), 128'(0));
        check("final_trig_busy", 128'(bus.o_busy), 128'(1));
        model_expand(K128, 0);
        run_to_done(1'b0, en, st);
        check("final_trig_cycles", 128'(en), 128'(cycles_of(0)));
        read_round(10, k);
        check("final_trig_r10", k, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reserved mode while idle: error pulse, state untouched
        for (int w = 0; w < 8; w++) rkey[32*w +: 32] = $urandom();
        start(rkey, 2'd3);
        check("mode3_err", 128'(bus.o_mode_err), 128'(1));
        check("mode3_idle", 128'(bus.o_busy), 128'(0));
        step();
        check("mode3_err_pulse", 128'(bus.o_mode_err), 128'(0));
        check_all("mode3");

        // Reserved mode while busy: o_busy unaffected, keys unaffected
        model_expand(K192, 1);
        start(K192, 2'd1);
        bus.i_valid = 1'b1; step(); step();
        bus.i_key = rkey; bus.i_key_mode = 2'd3; bus.i_trigger_schedule = 1'b1;
        step();
        bus.i_trigger_schedule = 1'b0; bus.i_valid = 1'b0;
        check("mode3_busy_err", 128'(bus.o_mode_err), 128'(1));
        check("mode3_busy_kept", 128'(bus.o_busy), 128'(1));
        run_to_done(1'b0, en, st);
        check_all("mode3_busy");

        // Asynchronous reset in the middle of an expansion
        start(K256, 2'd2);
        bus.i_valid = 1'b1;
        step(); step();
        read_round(0, k);
        check("busy_partial_r0", k, K256[255:128]);
        #3;
        rst = 1'b1;
        #1;
        check("arst_rd_key", bus.o_rd_key, 128'(0));
        check("arst_busy", 128'(bus.o_busy), 128'(0));
        check("arst_rd_valid", 128'(bus.o_rd_valid), 128'(0));
        step();
        rst = 1'b0;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (bus.o_done) dones++;
        end
        bus.i_valid = 1'b0;
        check("arst_no_done", 128'(dones), 128'(0));
        check("arst_idle", 128'(bus.o_busy), 128'(0));
        read_round(0, k);
        check("arst_regfile_r0", k, 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
